axi_burst_master: RTL and testbench
===================================

Name: axi_burst_master

Overview:
- AXI3-style master that turns one 128-bit cache-line request from the core into a single 4-beat, 32-bit INCR burst.
- Write requests become an AW/W/B transaction; read requests become an AR/R transaction.
- Sits between the core's memory port and master port 0 of the AXI interconnect, which feeds the boot ROM slave.
- Handles one transaction at a time and reports completion with one-cycle pulses.

Parameters:
- ID_W, 1, width of the AWID/BID/ARID/RID fields.
- ADDR_W, 32, address width.
- DATA_W, 32, AXI data-bus width.
- LINE_W, 128, core line width (always 4 × DATA_W).

Ports:
- M_AXI_ACLK  in  1  single clock.
- M_AXI_ARESETN  in  1  asynchronous active-low reset.
- Rvcore_valid_req_i  in  1  one-cycle request strobe.
- Rvcore_rw_i  in  1  0 = write line, 1 = read line.
- Rvcore_addr_i  in  32  line address.
- Rvcore_data_i  in  128  write line.
- axi_data_o  out  128  last read line.
- axi_rd_over_o  out  1  read-done pulse.
- axi_wr_over_o  out  1  write-done pulse.
- core_WAIT  in  1  interconnect busy; blocks issue of a new address.
- M_AXI_AWID  out  1
- M_AXI_AWADDR  out  32
- M_AXI_AWLEN  out  4
- M_AXI_AWSIZE  out  3
- M_AXI_AWBURST  out  2
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32
- M_AXI_WSTRB  out  4
- M_AXI_WLAST  out  1
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BID  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARID  out  1
- M_AXI_ARADDR  out  32
- M_AXI_ARLEN  out  4
- M_AXI_ARSIZE  out  3
- M_AXI_ARBURST  out  2
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RID  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RLAST  in  1
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Reset (asynchronous, active-low):
  - All VALID/READY/LAST outputs, both over pulses and axi_data_o are 0.
  - FSM in IDLE; beat counter 0.
- Constant fields:
  - AWID = ARID = 0.
  - AWLEN = ARLEN = 4'd3 (4 beats).
  - AWSIZE = ARSIZE = 3'b010 (4 bytes).
  - AWBURST = ARBURST = 2'b01 (INCR).
  - WSTRB = 4'hF.
- AWADDR/ARADDR = {latched_addr[31:4], 4'b0}, held stable while VALID is high.
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA.
- IDLE:
  - On a clock edge with Rvcore_valid_req_i=1, latch addr, data and rw.
  - Next state is WADDR (rw=0) or RADDR (rw=1).
  - Requests arriving outside IDLE are ignored (dropped).
- WADDR / RADDR:
  - Assert AWVALID/ARVALID only while core_WAIT=0.
  - Once VALID is asserted it stays high until the READY handshake, regardless of core_WAIT.
  - On handshake, drop VALID and go to WDATA / RDATA.
- WDATA:
  - WVALID=1.
  - WDATA = line[32*k+31:32*k], where k is the beat counter 0..3.
  - On each WVALID&&WREADY, k increments.
  - WLAST=1 exactly when k=3.
  - After the beat-3 handshake, drop WVALID and go to WRESP.
- WRESP:
  - BREADY=1.
  - On BVALID, pulse axi_wr_over_o for one cycle and go to IDLE.
  - BRESP/BID are ignored.
- RDATA:
  - RREADY=1.
  - On each RVALID handshake, store RDATA into word k of a line buffer and increment k.
  - On the handshake with RLAST=1 (or k=3):
    - Copy the complete line to axi_data_o (word 0 in bits [31:0]).
    - Pulse axi_rd_over_o for one cycle.
    - Go to IDLE.
  - RRESP/RID are ignored.
- axi_data_o holds its value until the next read completes.
- Earliest new request accepted: the cycle after the over pulse.
- Reset asserted mid-burst: immediate return to IDLE with all outputs at reset values; the partial transaction is abandoned.

Test Plan:
- Reset release, no request → all VALIDs 0, axi_data_o=0, both over pulses 0.
- Write, addr 0x0, data 128'h0303…03, all READYs tied high:
  - AW fires with AWADDR=0, AWLEN=3, AWSIZE=2, AWBURST=1.
  - 4 W beats of 0x03030303 with WLAST on beat 4 only.
  - axi_wr_over_o pulses one cycle after BVALID.
- Read, addr 0x0, slave returns words 0x11111111, 0x22222222, 0x33333333, 0x44444444:
  - axi_data_o = 128'h44444444_33333333_22222222_11111111.
  - axi_rd_over_o pulses for exactly one cycle.
- core_WAIT=1 while in RADDR → ARVALID stays 0; deassert core_WAIT → ARVALID rises the next cycle and holds until ARREADY.
- WREADY toggled randomly → beat order and WLAST position unchanged; a second request pulsed during WDATA is ignored.
- Reset asserted after 2 read beats → outputs return to reset values; a new read afterwards completes normally.

Source files
------------

// File: rtl/axi_burst_master.sv
// AXI3 burst master: turns one core cache-line request into a single
// 4-beat INCR burst (AW/W/B for writes, AR/R for reads), one at a time.
// Ports:
//   Rvcore_*_i        core request (strobe, rw, line address, write line)
//   axi_data_o        last completed read line (word 0 in [DATA_W-1:0])
//   axi_rd_over_o     one-cycle read-done pulse
//   axi_wr_over_o     one-cycle write-done pulse
//   core_WAIT         interconnect busy; holds off raising AWVALID/ARVALID
//   M_AXI_*           AXI3 master channels AW, W, B, AR, R
module axi_burst_master #(
    parameter int unsigned ID_W   = 1,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINE_W = 128
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,
    input  logic                  Rvcore_valid_req_i,
    input  logic                  Rvcore_rw_i,
    input  logic [ADDR_W-1:0]     Rvcore_addr_i,
    input  logic [LINE_W-1:0]     Rvcore_data_i,
    output logic [LINE_W-1:0]     axi_data_o,
    output logic                  axi_rd_over_o,
    output logic                  axi_wr_over_o,
    input  logic                  core_WAIT,
    output logic [ID_W-1:0]       M_AXI_AWID,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [3:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [ID_W-1:0]       M_AXI_BID,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ID_W-1:0]       M_AXI_ARID,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic [3:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [ID_W-1:0]       M_AXI_RID,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    localparam int unsigned BEATS  = LINE_W / DATA_W;
    localparam int unsigned CNT_W  = $clog2(BEATS);
    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [3:0]       AXLEN     = 4'(BEATS - 1);
    localparam logic [2:0]       AXSIZE    = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {
        IDLE, WADDR, WDATA, WRESP, RADDR, RDATA
    } state_t;

    typedef logic [BEATS-1:0][DATA_W-1:0] line_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    line_t              line_q, line_d;
    line_t              rbuf_q, rbuf_d;
    line_t              data_q, data_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               wlast_q, wlast_d;
    logic               bready_q, bready_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic               wr_over_q, wr_over_d;
    logic               rd_over_q, rd_over_d;
    logic               unused_inputs;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Response IDs/codes are not acted on; low address bits are forced to zero.
    assign unused_inputs = ^{M_AXI_BID, M_AXI_BRESP, M_AXI_RID, M_AXI_RRESP,
                             Rvcore_addr_i[OFF_W-1:0]};

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        line_d    = line_q;
        rbuf_d    = rbuf_q;
        data_d    = data_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        wlast_d   = wlast_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        wr_over_d = 1'b0;
        rd_over_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Rvcore_valid_req_i) begin
                    addr_d  = {Rvcore_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
                    line_d  = Rvcore_data_i;
                    cnt_d   = '0;
                    state_d = Rvcore_rw_i ? RADDR : WADDR;
                end
            end
            // Once raised, AWVALID ignores core_WAIT until the handshake
            WADDR: begin
                if (!awvalid_q) begin
                    awvalid_d = !core_WAIT;
                end else if (M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b1;
                    wdata_d   = line_q[0];
                    wlast_d   = 1'b0;
                    state_d   = WDATA;
                end
            end
            // Next beat's data and WLAST are preloaded on each handshake
            WDATA: begin
                if (M_AXI_WREADY) begin
                    if (cnt_q == LAST_BEAT) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        bready_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = WRESP;
                    end else begin
                        cnt_d   = cnt_inc;
                        wdata_d = line_q[cnt_inc];
                        wlast_d = (cnt_inc == LAST_BEAT);
                    end
                end
            end
            WRESP: begin
                if (M_AXI_BVALID) begin
                    bready_d  = 1'b0;
                    wr_over_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            RADDR: begin
                if (!arvalid_q) begin
                    arvalid_d = !core_WAIT;
                end else if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = RDATA;
                end
            end
            // Either RLAST or the beat count closes the burst
            RDATA: begin
                if (M_AXI_RVALID) begin
                    rbuf_d[cnt_q] = M_AXI_RDATA;
                    if (M_AXI_RLAST || (cnt_q == LAST_BEAT)) begin
                        data_d    = rbuf_d;
                        rd_over_d = 1'b1;
                        rready_d  = 1'b0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            line_q    <= '0;
            rbuf_q    <= '0;
            data_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            wr_over_q <= 1'b0;
            rd_over_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
            rbuf_q    <= rbuf_d;
            data_q    <= data_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            wlast_q   <= wlast_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            wr_over_q <= wr_over_d;
            rd_over_q <= rd_over_d;
        end
    end

    assign axi_data_o    = data_q;
    assign axi_rd_over_o = rd_over_q;
    assign axi_wr_over_o = wr_over_q;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = AXLEN;
    assign M_AXI_AWSIZE  = AXSIZE;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = wlast_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = AXLEN;
    assign M_AXI_ARSIZE  = AXSIZE;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: behavioural AXI slave with scoreboard queues,
// a table of request vectors, and hand-written corner-case sequences.
module tb_axi_burst_master;

    logic         clk;
    logic         rst_n;
    logic         req;
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [127:0] axi_data;
    logic         rd_over;
    logic         wr_over;
    logic         core_wait;
    logic [0:0]   awid;
    logic [31:0]  awaddr;
    logic [3:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [0:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [0:0]   arid;
    logic [31:0]  araddr;
    logic [3:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [0:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    axi_burst_master #(.ID_W(1), .ADDR_W(32), .DATA_W(32), .LINE_W(128)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .Rvcore_valid_req_i(req), .Rvcore_rw_i(rw),
        .Rvcore_addr_i(addr), .Rvcore_data_i(data),
        .axi_data_o(axi_data), .axi_rd_over_o(rd_over), .axi_wr_over_o(wr_over),
        .core_WAIT(core_wait),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen),
        .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
        .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    typedef struct {
        bit           rw;
        logic [31:0]  addr;
        logic [127:0] line;
        bit           rand_w;
        logic [31:0]  exp_addr;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0]      exp_aw[$];
    logic [31:0]      exp_ar[$];
    logic [32:0]      exp_w[$];
    logic [127:0]     exp_rd[$];
    logic [3:0][31:0] rd_line;
    bit               rand_mode  = 1'b0;
    bit               arready_en = 1'b1;
    bit               b_pending;
    bit               r_active;
    int               r_idx;
    int               last_b_cyc;
    int               last_r_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave: observe handshakes at negedge (they complete at the next posedge),
    // then drive the slave-side signals just after that posedge.
    initial begin
        logic [31:0] a;
        logic [32:0] w;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rid = '0; rresp = '0;
        b_pending = 1'b0; r_active = 1'b0; r_idx = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_pending = 1'b0;
                r_active  = 1'b0;
                r_idx     = 0;
            end else begin
                if (awvalid && awready) begin
                    if (exp_aw.size() == 0) begin
                        check("aw_unexpected", 128'(awvalid), 128'(0));
                    end else begin
                        a = exp_aw.pop_front();
                        check("awaddr", 128'(awaddr), 128'(a));
                        check("awlen", 128'(awlen), 128'(3));
                        check("awsize", 128'(awsize), 128'(2));
                        check("awburst", 128'(awburst), 128'(1));
                        check("awid", 128'(awid), 128'(0));
                    end
                end
                if (bvalid && bready) begin
                    b_pending  = 1'b0;
                    last_b_cyc = cyc;
                end
                if (wvalid && wready) begin
                    if (exp_w.size() == 0) begin
                        check("w_unexpected", 128'(wvalid), 128'(0));
                    end else begin
                        w = exp_w.pop_front();
                        check("wdata", 128'(wdata), 128'(w[31:0]));
                        check("wlast", 128'(wlast), 128'(w[32]));
                        check("wstrb", 128'(wstrb), 128'(4'hF));
                    end
                    if (wlast) b_pending = 1'b1;
                end
                if (arvalid && arready) begin
                    if (exp_ar.size() == 0) begin
                        check("ar_unexpected", 128'(arvalid), 128'(0));
                    end else begin
                        a = exp_ar.pop_front();
                        check("araddr", 128'(araddr), 128'(a));
                        check("arlen", 128'(arlen), 128'(3));
                        check("arsize", 128'(arsize), 128'(2));
                        check("arburst", 128'(arburst), 128'(1));
                        check("arid", 128'(arid), 128'(0));
                    end
                    r_active = 1'b1;
                    r_idx    = 0;
                end
                if (rvalid && rready) begin
                    if (rlast) begin
                        r_active   = 1'b0;
                        last_r_cyc = cyc;
                    end
                    r_idx++;
                end
            end
            @(posedge clk);
            #1;
            awready = 1'b1;
            wready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            bvalid  = b_pending;
            arready = arready_en;
            rvalid  = r_active && (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
            rdata   = rd_line[2'(r_idx)];
            rlast   = (r_idx == 3);
        end
    end

    task automatic push_exp(input bit t_rw, input logic [3:0][31:0] line, input logic [31:0] exp_addr);
        if (t_rw) begin
            exp_ar.push_back(exp_addr);
            exp_rd.push_back(line);
            rd_line = line;
        end else begin
            exp_aw.push_back(exp_addr);
            for (int k = 0; k < 4; k++) exp_w.push_back({(k == 3), line[2'(k)]});
        end
    endtask

    task automatic drive_req(input bit t_rw, input logic [31:0] t_addr, input logic [127:0] line);
        @(posedge clk); #1;
        req = 1'b1; rw = t_rw; addr = t_addr; data = line;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    // Wait for the done pulse, score it, and confirm it lasts one cycle
    task automatic wait_over(input bit t_rw);
        bit seen = 1'b0;
        logic [127:0] e;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (t_rw ? rd_over : wr_over) seen = 1'b1;
        end
        check(t_rw ? "rd_over_seen" : "wr_over_seen", 128'(seen), 128'(1));
        if (seen) begin
            if (t_rw) begin
                e = (exp_rd.size() != 0) ? exp_rd.pop_front() : 128'hx;
                check("rd_line", axi_data, e);
                check("rd_over_latency", 128'(cyc), 128'(last_r_cyc + 1));
            end else begin
                check("wr_over_latency", 128'(cyc), 128'(last_b_cyc + 1));
            end
            @(negedge clk);
            check("over_pulse_width", 128'(t_rw ? rd_over : wr_over), 128'(0));
        end
    endtask

    initial begin
        vec_t         vecs[6];
        logic [127:0] last_rd;
        bit           seen;

        vecs[0] = '{1'b0, 32'h0000_0000, {16{8'h03}}, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b1, 32'h0000_0000, 128'h44444444_33333333_22222222_11111111, 1'b0, 32'h0000_0000};
        vecs[2] = '{1'b0, 32'h1234_567C, 128'hdeadbeef_cafef00d_01234567_89abcdef, 1'b0, 32'h1234_5670};
        vecs[3] = '{1'b1, 32'h0000_ABCD, 128'h0f0f0f0f_a5a5a5a5_ffffffff_00000001, 1'b1, 32'h0000_ABC0};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 128'h76543210_fedcba98_55aa55aa_aa55aa55, 1'b1, 32'hFFFF_FFF0};
        vecs[5] = '{1'b1, 32'h8000_0010, 128'h0badf00d_13579bdf_2468ace0_c0ffee00, 1'b1, 32'h8000_0010};

        rst_n = 1'b0; req = 1'b0; rw = 1'b0; addr = '0; data = '0; core_wait = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        @(negedge clk);
        check("rst_awvalid", 128'(awvalid), 128'(0));
        check("rst_wvalid", 128'(wvalid), 128'(0));
        check("rst_wlast", 128'(wlast), 128'(0));
        check("rst_bready", 128'(bready), 128'(0));
        check("rst_arvalid", 128'(arvalid), 128'(0));
        check("rst_rready", 128'(rready), 128'(0));
        check("rst_rd_over", 128'(rd_over), 128'(0));
        check("rst_wr_over", 128'(wr_over), 128'(0));
        check("rst_data", axi_data, 128'(0));

        last_rd = '0;
        for (int i = 0; i < 6; i++) begin
            rand_mode = vecs[i].rand_w;
            push_exp(vecs[i].rw, vecs[i].line, vecs[i].exp_addr);
            drive_req(vecs[i].rw, vecs[i].addr, vecs[i].line);
            wait_over(vecs[i].rw);
            if (vecs[i].rw) last_rd = vecs[i].line;
            else check("data_hold", axi_data, last_rd);
        end

        // core_WAIT holds off ARVALID; once raised it holds until ARREADY
        rand_mode = 1'b0; core_wait = 1'b1; arready_en = 1'b0;
        push_exp(1'b1, 128'h99999999_88888888_77777777_66666666, 32'h0000_0040);
        drive_req(1'b1, 32'h0000_0044, 128'h0);
        repeat (4) begin
            @(negedge clk);
            check("arvalid_wait", 128'(arvalid), 128'(0));
        end
        @(posedge clk); #1 core_wait = 1'b0;
        @(negedge clk);
        check("arvalid_pre_rise", 128'(arvalid), 128'(0));
        @(negedge clk);
        check("arvalid_rise", 128'(arvalid), 128'(1));
        core_wait = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("arvalid_hold", 128'(arvalid), 128'(1));
        end
        arready_en = 1'b1;
        core_wait  = 1'b0;
        wait_over(1'b1);

        // Random WREADY with a stray read request during WDATA
        rand_mode = 1'b1;
        push_exp(1'b0, 128'h0c0c0c0c_0b0b0b0b_0a0a0a0a_09090909, 32'h0000_0100);
        drive_req(1'b0, 32'h0000_0100, 128'h0c0c0c0c_0b0b0b0b_0a0a0a0a_09090909);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (wvalid) seen = 1'b1;
        end
        check("wvalid_seen", 128'(seen), 128'(1));
        @(posedge clk); #1;
        req = 1'b1; rw = 1'b1; addr = 32'h0000_0200;
        @(posedge clk); #1;
        req = 1'b0;
        wait_over(1'b0);
        repeat (8) @(negedge clk);
        check("stray_ar_ignored", 128'(arvalid), 128'(0));
        check("stray_rready_low", 128'(rready), 128'(0));

        // Reset after two read beats, then a clean read
        rand_mode = 1'b0;
        push_exp(1'b1, 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa, 32'h0000_0300);
        drive_req(1'b1, 32'h0000_0300, 128'h0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            if (r_idx == 2) seen = 1'b1;
        end
        check("two_beats_seen", 128'(seen), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rready", 128'(rready), 128'(0));
        check("midrst_arvalid", 128'(arvalid), 128'(0));
        check("midrst_rd_over", 128'(rd_over), 128'(0));
        check("midrst_awvalid", 128'(awvalid), 128'(0));
        check("midrst_wvalid", 128'(wvalid), 128'(0));
        check("midrst_bready", 128'(bready), 128'(0));
        check("midrst_data", axi_data, 128'(0));
        exp_rd.delete();
        exp_ar.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        push_exp(1'b1, 128'h01020304_05060708_090a0b0c_0d0e0f10, 32'h0000_0400);
        drive_req(1'b1, 32'h0000_0408, 128'h0);
        wait_over(1'b1);

        repeat (4) @(negedge clk);
        check("queues_drained", 128'(exp_aw.size() + exp_ar.size() + exp_w.size() + exp_rd.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
